// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider; the dbz line exists only
// when SEQ_DIVIDER_DBZ_EN is defined.
interface seq_divider_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef SEQ_DIVIDER_DBZ_EN
    logic         dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
`endif
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional SEQ_DIVIDER_DBZ_EN: divide-by-zero shortcut to DONE with a dbz flag.
module seq_divider #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     rem_reg, rem_next;
    logic [N-1:0]     quo_reg, quo_next;
    logic [N-1:0]     div_reg, div_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`ifdef SEQ_DIVIDER_DBZ_EN
    logic             dbz_reg, dbz_next;
`endif

    // After k CALC steps rem < 2^k, so its MSB is always clear before the
    // shift and the N-bit shifted value never loses a bit.
    logic [N-1:0] rem_shift;
    logic [N:0]   trial;
    assign rem_shift = {rem_reg[N-2:0], quo_reg[N-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, div_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef SEQ_DIVIDER_DBZ_EN
                    state_next = (bus.divisor == '0) ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt_reg == CNT_W'(N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == IDLE);
        bus.out_valid = (state_reg == DONE);
    end

    assign bus.quotient  = quo_reg;
    assign bus.remainder = rem_reg;
`ifdef SEQ_DIVIDER_DBZ_EN
    assign bus.dbz       = dbz_reg;
`endif

    always_comb begin
        rem_next = rem_reg;
        quo_next = quo_reg;
        div_next = div_reg;
        cnt_next = cnt_reg;
`ifdef SEQ_DIVIDER_DBZ_EN
        dbz_next = dbz_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    rem_next = '0;
                    quo_next = bus.dividend;
                    div_next = bus.divisor;
                    cnt_next = '0;
`ifdef SEQ_DIVIDER_DBZ_EN
                    if (bus.divisor == '0) begin
                        rem_next = bus.dividend;
                        quo_next = '1;
                        dbz_next = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                // Borrow out of the N+1-bit subtract means the trial failed.
                rem_next = trial[N] ? rem_shift : trial[N-1:0];
                quo_next = {quo_reg[N-2:0], ~trial[N]};
                cnt_next = cnt_reg + 1'b1;
            end
            DONE: begin
`ifdef SEQ_DIVIDER_DBZ_EN
                if (bus.out_ready) begin
                    dbz_next = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg <= '0;
            quo_reg <= '0;
            div_reg <= '0;
            cnt_reg <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz_reg <= 1'b0;
`endif
        end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            div_reg <= div_next;
            cnt_reg <= cnt_next;
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz_reg <= dbz_next;
`endif
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results and a
// negedge monitor checks each result handoff, hold stability and latency.
module tb_seq_divider;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_divider_if #(.N(N)) bus ();
    seq_divider #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_out  = 0;
    int n_push = 0;
    int n_abort = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, where every signal is settled.
    initial begin : monitor
        logic prev_valid;
        logic chk_idle;
        int first_cyc;
        logic [N-1:0] held_q, held_r;
        exp_t e;
        prev_valid = 1'b0;
        chk_idle = 1'b0;
        first_cyc = 0;
        held_q = '0;
        held_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                chk_idle = 1'b0;
            end else begin
                if (chk_idle) begin
                    chk("idle_in_ready", bus.in_ready, 1);
                    chk("idle_out_valid", bus.out_valid, 0);
                    chk_idle = 1'b0;
                end
                if (bus.in_valid && bus.in_ready) n_acc++;
`ifdef SEQ_DIVIDER_DBZ_EN
                if (!bus.out_valid) chk("dbz_when_idle", bus.dbz, 0);
`endif
                if (bus.out_valid) begin
                    chk("no_accept_while_done", bus.in_ready, 0);
                    if (!prev_valid) begin
                        first_cyc = cyc;
                        held_q = bus.quotient;
                        held_r = bus.remainder;
                    end else begin
                        chk("hold_quotient", bus.quotient, held_q);
                        chk("hold_remainder", bus.remainder, held_r);
                    end
                    if (bus.out_ready) begin
                        n_out++;
                        chk("scoreboard_nonempty", (exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            $display("txn %0d: q=%0d r=%0d lat=%0d (exp q=%0d r=%0d lat=%0d)",
                                     n_out, bus.quotient, bus.remainder, first_cyc - e.acc,
                                     e.q, e.r, e.lat);
                            chk("quotient", bus.quotient, e.q);
                            chk("remainder", bus.remainder, e.r);
                            chk("latency", first_cyc - e.acc, e.lat);
`ifdef SEQ_DIVIDER_DBZ_EN
                            chk("dbz", bus.dbz, e.dbz);
`endif
                        end
                        chk_idle = 1'b1;
                    end
                end
                prev_valid = bus.out_valid;
            end
        end
    end

    // Present operands until accepted, then queue the expected result.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er);
        exp_t e;
        int n;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.q = eq;
            e.r = er;
            e.acc = cyc;
            e.dbz = 1'b0;
            e.lat = N;
`ifdef SEQ_DIVIDER_DBZ_EN
            if (b == '0) begin
                e.dbz = 1'b1;
                e.lat = 1;
            end
`endif
            exp_q.push_back(e);
            n_push++;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [N-1:0] a, b;
        int n;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
`ifdef SEQ_DIVIDER_DBZ_EN
        chk("rst_dbz", bus.dbz, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, each drained so latency is measured in isolation.
        send(8'd200, 8'd7,   8'd28,  8'd4);   drain();
        send(8'd255, 8'd1,   8'd255, 8'd0);   drain();
        send(8'd5,   8'd9,   8'd0,   8'd5);   drain();
        send(8'd0,   8'd13,  8'd0,   8'd0);   drain();
        send(8'd128, 8'd128, 8'd1,   8'd0);   drain();
        send(8'd100, 8'd0,   8'd255, 8'd100); drain();
        send(8'd255, 8'd255, 8'd1,   8'd0);   drain();
        send(8'd254, 8'd255, 8'd0,   8'd254); drain();

        // Backpressure: result held 5 cycles while a new request waits.
        bus.out_ready = 1'b0;
        send(8'd77, 8'd10, 8'd7, 8'd7);
        fork
            send(8'd9, 8'd3, 8'd3, 8'd0);
            begin
                n = 0;
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_out_valid_seen", bus.out_valid, 1);
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the fourth CALC cycle aborts the division.
        send(8'd200, 8'd7, 8'd28, 8'd4);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        exp_q.delete();
        n_abort++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", bus.in_ready, 1);
        send(8'd50, 8'd6, 8'd8, 8'd2);
        drain();

        // Back-to-back stream against a reference model.
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            send(a, b, a / b, a % b);
        end
        drain();

        chk("accept_count", n_acc, n_push);
        chk("handoff_count", n_out, n_push - n_abort);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring integer divider, the inverse of the combinational shift-add multiplier in the arithmetic library.
- Computes unsigned quotient and remainder of an N-bit dividend by an N-bit divisor, one quotient bit per clock.
- Uses valid/ready handshakes on both input and output.
- Used by the NTT datapath for modulus setup and for software-visible reduction checks, where area matters more than latency.

Parameters:
- N, 8, operand width in bits; quotient and remainder are N bits; N >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept operands.
- dividend  input  N  unsigned dividend a.
- divisor  input  N  unsigned divisor b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  floor(a/b).
- remainder  output  N  a mod b.
- dbz  output  1  divide-by-zero flag; present only with SEQ_DIVIDER_DBZ_EN.

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low.
  - While rst_n is low: state=IDLE, out_valid=0, quotient=0, remainder=0, dbz=0, counter=0.
  - in_ready is 1 once state is IDLE.
  - Reset mid-operation aborts the division and drops any pending result.
- FSM states IDLE, CALC, DONE:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on a rising edge with in_valid && in_ready:
  - rem <= 0, quo <= dividend, div_r <= divisor, cnt <= 0.
  - Go to CALC.
  - Operands are sampled only at this edge; later input changes are ignored.
- CALC, each cycle:
  - {rem,quo} shifted left 1, with the MSB of quo entering the LSB of rem.
  - Trial difference t = {1'b0,rem_shifted} - {1'b0,div_r}, computed at N+1 bits.
  - If t is non-negative: rem <= t[N-1:0] and the LSB of quo is set to 1.
  - Otherwise: rem keeps the shifted value and the LSB of quo is 0.
  - cnt increments each cycle. After the N-th CALC cycle (cnt==N-1), go to DONE.
- Latency: operands accepted at edge k → out_valid=1 after edge k+N+... precisely, out_valid rises after edge k+N (N CALC cycles).
- DONE:
  - quotient and remainder are driven from the registers and held stable while out_valid && !out_ready (backpressure, unbounded).
  - On an edge with out_ready=1, go to IDLE. out_valid drops and in_ready rises the next cycle.
  - There is no accept in the same cycle as the result handoff. Throughput is one division per N+2 cycles.
- Arithmetic:
  - The trial subtract is N+1 bits wide, so a carry-out never aliases.
  - The remainder is always < divisor when divisor != 0.
- Divide by zero (no macro): the algorithm runs normally and yields quotient = all ones and remainder = dividend, with the normal N-cycle latency.
- in_valid held high during CALC/DONE is ignored; the upstream must hold operands until in_ready.

Optional Feature:
- Macro SEQ_DIVIDER_DBZ_EN.
- Defined:
  - Adds the dbz output.
  - In IDLE, accepting divisor==0 goes directly to DONE on the next edge (latency 1) with quotient=all ones, remainder=dividend, dbz=1.
  - dbz is cleared on leaving DONE and is otherwise 0.
- Undefined:
  - No dbz port.
  - Divide by zero takes the full N-cycle path with the same quotient/remainder values.

Test Plan:
- N=8, a=200, b=7, out_ready=1 → out_valid after exactly 8 cycles from accept; quotient=28, remainder=4; in_ready returns 1 the cycle after handoff.
- a=255, b=1 → 255/0. a=5, b=9 → 0/5. a=0, b=13 → 0/0. a=128, b=128 → 1/0.
- a=100, b=0 → quotient=255, remainder=100.
  - Without macro: 8-cycle latency, no dbz.
  - With SEQ_DIVIDER_DBZ_EN: 1-cycle latency, dbz=1 only while out_valid.
- Backpressure: a=77, b=10, out_ready low 5 cycles after out_valid → outputs hold 7/7 stable, no new accept while in_valid stays high. Release out_ready → single handoff.
- Deassert rst_n during cycle 4 of CALC (a=200, b=7) → out_valid=0 immediately, in_ready=1 after release. Next division a=50, b=6 → 8/2, no residue from the aborted operation.
- Randomized back-to-back stream of 1000 operand pairs against the reference model q=a/b, r=a%b (b≠0), checking handshake counts match.
